// File: rtl/top_module_xnor_pkg.sv
// Shared constants for the XNOR comparator block and its event counters.
package top_module_xnor_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned CNT_W_MIN = 4;
    localparam int unsigned CNT_W_MAX = 32;

endpackage

// File: rtl/top_module_xnor_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high clear.
module sat_counter
    import top_module_xnor_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Clear wins over any pending increment or saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/top_module_xnor.sv
// Combinational XNOR of x and y, with a registered copy and saturating counters
// of sampled cycles and of cycles where x equals y.
module top_module_xnor
    import top_module_xnor_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             y,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] sample_count,
    output logic             sat
);

    if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
        $error("top_module_xnor: CNT_W out of range");
    end

    logic z_reg_q;
    logic z_reg_d;

    assign z = ~(x ^ y);

    always_comb begin
        z_reg_d = z;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_reg_q <= 1'b0;
        end else begin
            z_reg_q <= z_reg_d;
        end
    end

    assign z_q = z_reg_q;

    // Both counters clear together, so eq_count can never overtake sample_count.
    sat_counter #(.WIDTH(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (z),
        .count (eq_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .count (sample_count)
    );

    assign sat = (eq_count == '1) || (sample_count == '1);

endmodule

// File: tb/tb_top_module_xnor.sv
// Scoreboard bench for top_module_xnor at the default width and at CNT_W=4.
module tb_top_module_xnor;

    logic        clk;
    logic        reset;
    logic        x;
    logic        y;
    logic        z;
    logic        z_q;
    logic [15:0] eq_count;
    logic [15:0] sample_count;
    logic        sat;
    logic        z4;
    logic        z_q4;
    logic [3:0]  eq_count4;
    logic [3:0]  sample_count4;
    logic        sat4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        zq;
        logic [15:0] eq;
        logic [15:0] smp;
        logic        sat;
        logic [3:0]  eq4;
        logic [3:0]  smp4;
        logic        sat4;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic        m_zq   = 1'b0;
    logic [15:0] m_eq   = '0;
    logic [15:0] m_smp  = '0;
    logic [3:0]  m_eq4  = '0;
    logic [3:0]  m_smp4 = '0;

    top_module_xnor dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .z            (z),
        .z_q          (z_q),
        .eq_count     (eq_count),
        .sample_count (sample_count),
        .sat          (sat)
    );

    top_module_xnor #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .z            (z4),
        .z_q          (z_q4),
        .eq_count     (eq_count4),
        .sample_count (sample_count4),
        .sat          (sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_z(input string tag);
        logic e;
        e = ~(x ^ y);
        check(tag, {31'd0, z}, {31'd0, e});
        check({tag, "_w4"}, {31'd0, z4}, {31'd0, e});
    endtask

    // Advance the model for the coming rising edge, queue the expectation,
    // then compare once the DUT has taken that edge.
    task automatic tick();
        exp_t e;
        exp_t got;
        if (reset) begin
            m_zq = 1'b0; m_eq = '0; m_smp = '0; m_eq4 = '0; m_smp4 = '0;
        end else begin
            m_zq = (x == y);
            if (m_smp != 16'hFFFF) m_smp = m_smp + 16'd1;
            if ((x == y) && (m_eq != 16'hFFFF)) m_eq = m_eq + 16'd1;
            if (m_smp4 != 4'hF) m_smp4 = m_smp4 + 4'd1;
            if ((x == y) && (m_eq4 != 4'hF)) m_eq4 = m_eq4 + 4'd1;
        end
        e.zq   = m_zq;
        e.eq   = m_eq;
        e.smp  = m_smp;
        e.sat  = (m_eq == 16'hFFFF) || (m_smp == 16'hFFFF);
        e.eq4  = m_eq4;
        e.smp4 = m_smp4;
        e.sat4 = (m_eq4 == 4'hF) || (m_smp4 == 4'hF);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("z_q",           {31'd0, z_q},           {31'd0, got.zq});
        check("eq_count",      {16'd0, eq_count},      {16'd0, got.eq});
        check("sample_count",  {16'd0, sample_count},  {16'd0, got.smp});
        check("sat",           {31'd0, sat},           {31'd0, got.sat});
        check("z_q_w4",        {31'd0, z_q4},          {31'd0, got.zq});
        check("eq_count_w4",   {28'd0, eq_count4},     {28'd0, got.eq4});
        check("sample_cnt_w4", {28'd0, sample_count4}, {28'd0, got.smp4});
        check("sat_w4",        {31'd0, sat4},          {31'd0, got.sat4});
    endtask

    task automatic drive(input logic r, input logic xv, input logic yv);
        @(negedge clk);
        reset = r;
        x     = xv;
        y     = yv;
        #1;
        check_z("z_comb");
        tick();
    endtask

    initial begin
        reset = 1'b1;
        x     = 1'b0;
        y     = 1'b0;

        // Reset two cycles, then five equal cycles
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        check("reset_eq", {16'd0, eq_count}, 32'd0);
        check("reset_smp", {16'd0, sample_count}, 32'd0);
        check("reset_zq", {31'd0, z_q}, 32'd0);
        repeat (5) drive(1'b0, 1'b1, 1'b1);
        check("five_eq", {16'd0, eq_count}, 32'd5);
        check("five_smp", {16'd0, sample_count}, 32'd5);
        check("five_zq", {31'd0, z_q}, 32'd1);

        // Truth-table sweep within one low clock phase
        @(negedge clk);
        reset = 1'b0;
        for (int unsigned v = 0; v < 4; v++) begin
            {y, x} = 2'(v);
            #1;
            check($sformatf("sweep_%0d", v), {31'd0, z}, ((v == 0) || (v == 3)) ? 32'd1 : 32'd0);
        end
        tick();

        // Alternate unequal/equal for ten cycles
        drive(1'b1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        check("alt_eq", {16'd0, eq_count}, 32'd5);
        check("alt_smp", {16'd0, sample_count}, 32'd10);
        check("alt_zq", {31'd0, z_q}, 32'd1);

        // Counters at 7, then reset with x == y
        drive(1'b1, 1'b0, 1'b0);
        repeat (7) drive(1'b0, 1'b1, 1'b1);
        check("pre_rst_eq", {16'd0, eq_count}, 32'd7);
        drive(1'b1, 1'b1, 1'b1);
        check("mid_rst_eq", {16'd0, eq_count}, 32'd0);
        check("mid_rst_smp", {16'd0, sample_count}, 32'd0);
        check("mid_rst_z", {31'd0, z}, 32'd1);

        // Saturation of the 4-bit instance
        repeat (20) drive(1'b0, 1'b0, 1'b0);
        check("sat4_eq", {28'd0, eq_count4}, 32'd15);
        check("sat4_smp", {28'd0, sample_count4}, 32'd15);
        check("sat4_flag", {31'd0, sat4}, 32'd1);
        check("wide_not_sat", {31'd0, sat}, 32'd0);

        // Random inputs changed on both edges
        for (int unsigned i = 0; i < 100; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom));
            x = 1'($urandom);
            y = 1'($urandom);
            #1;
            check_z("z_rand_pos");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
